vga_fb_arbiter: RTL and testbench

Single-port framebuffer arbiter between the VGA scan-out path and a pixel writer. Sits between `vga_ctrl` and the 24-bit framebuffer RAM, which is addressed `{h_addr[9:0], v_addr[8:0]}`.
- Display reads always win. Writer pixels are buffered in a small FIFO and drained into cycles where the display is idle: blanking or invalid pixels.
- An optional clear engine fills the whole framebuffer with one colour using the same idle slots.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_wr_fifo.sv | 43 ++++
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
// Contents: FB_ADDR_W, PIX_W, clr_state_t, wr_pix_t (FIFO entry).
package vga_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int PIX_W     = 24;

    typedef enum logic [1:0] {
        IDLE,
        CLR_DRAIN,
        CLR_SWEEP
    } clr_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } wr_pix_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous FIFO buffering writer pixels until the RAM port is idle.
// Ports: clk, reset (async, active-low), push/din, pop, full, empty, head.
module vga_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 43
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + (AW+1)'(1);
            if (pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win, writer pixels drain
// from a FIFO into idle slots, optional clear engine (VGA_FB_ARB_CLEAR_EN).
// Ports: clk, reset (async, active-low); disp_req/disp_addr -> disp_data,
// disp_dvalid; wr_valid/wr_addr/wr_data -> wr_ready; clear_start,
// clear_color -> clear_busy; ram_addr/ram_we/ram_wdata, ram_rdata.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int FB_WORDS    = 327680
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 disp_req,
    input  logic [FB_ADDR_W-1:0] disp_addr,
    output logic [PIX_W-1:0]     disp_data,
    output logic                 disp_dvalid,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic                 clear_start,
    input  logic [PIX_W-1:0]     clear_color,
    output logic                 clear_busy,
    output logic [FB_ADDR_W-1:0] ram_addr,
    output logic                 ram_we,
    output logic [PIX_W-1:0]     ram_wdata,
    input  logic [PIX_W-1:0]     ram_rdata
);

    wr_pix_t                w_push_pix;
    wr_pix_t                w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_clr_wr;
    logic [FB_ADDR_W-1:0]   w_clr_addr;
    logic [PIX_W-1:0]       w_clr_data;
    logic                   r_dvalid;

    assign disp_data   = ram_rdata;
    assign disp_dvalid = r_dvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_dvalid <= 1'b0;
        else        r_dvalid <= disp_req;
    end

    assign w_push_pix = '{addr: wr_addr, data: wr_data};
    assign wr_ready   = !w_full && !clear_busy;
    assign w_push     = wr_valid && wr_ready;
    assign w_pop      = !disp_req && !w_empty;

    vga_wr_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     ($bits(wr_pix_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_pix),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

`ifdef VGA_FB_ARB_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_WORDS - 1);

    clr_state_t           r_state;
    clr_state_t           w_state_nxt;
    logic [FB_ADDR_W-1:0] r_clr_cnt;
    logic [FB_ADDR_W-1:0] w_clr_cnt_nxt;
    logic [PIX_W-1:0]     r_clr_color;
    logic [PIX_W-1:0]     w_clr_color_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_clr_color <= w_clr_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_clr_color_nxt = r_clr_color;
        w_clr_wr        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_nxt     = CLR_DRAIN;
                    w_clr_cnt_nxt   = '0;
                    w_clr_color_nxt = clear_color;
                end
            end
            CLR_DRAIN: begin
                if (w_empty) w_state_nxt = CLR_SWEEP;
            end
            CLR_SWEEP: begin
                // Sweep only advances on slots the display leaves free.
                if (!disp_req && w_empty) begin
                    w_clr_wr = 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        w_state_nxt   = IDLE;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + FB_ADDR_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign clear_busy = (r_state != IDLE);
    assign w_clr_addr = r_clr_cnt;
    assign w_clr_data = r_clr_color;
`else
    logic w_unused;

    assign w_unused   = ^{clear_start, clear_color, (FB_WORDS > 0)};
    assign clear_busy = 1'b0;
    assign w_clr_wr   = 1'b0;
    assign w_clr_addr = '0;
    assign w_clr_data = '0;
`endif

    // Grant mux: display read, then FIFO head, then clear sweep.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (!w_empty) begin
            ram_we    = 1'b1;
            ram_addr  = w_head.addr;
            ram_wdata = w_head.data;
        end else if (w_clr_wr) begin
            ram_we    = 1'b1;
            ram_addr  = w_clr_addr;
            ram_wdata = w_clr_data;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: display pass-through, blanking writes,
// backpressure, push/pop overlap, clear engine and reset behaviour.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [23:0] disp_data;
    logic        disp_dvalid;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        clear_start;
    logic [23:0] clear_color;
    logic        clear_busy;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .WFIFO_DEPTH (4),
        .FB_WORDS    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_dvalid (disp_dvalid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [18:0] a,
                             input logic [23:0] d);
        chk({tag, "_we"}, 64'(ram_we), 64'd1);
        chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
        chk({tag, "_wdata"}, 64'(ram_wdata), 64'(d));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
        chk({tag, "_dvalid"}, 64'(disp_dvalid), 64'd0);
        chk({tag, "_busy"}, 64'(clear_busy), 64'd0);
        chk({tag, "_we"}, 64'(ram_we), 64'd0);
        chk({tag, "_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(ram_wdata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        disp_req    = 1'b0;
        disp_addr   = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        clear_start = 1'b0;
        clear_color = '0;
        ram_rdata   = 24'hABCDEF;

        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b1;
        tick();

        // Display only: addresses 0..639.
        for (int a = 0; a < 640; a++) begin
            disp_req  = 1'b1;
            disp_addr = 19'(a);
            #1;
            chk("disp_we", 64'(ram_we), 64'd0);
            chk("disp_addr", 64'(ram_addr), 64'(a));
            if (a == 0) chk("disp_dvalid0", 64'(disp_dvalid), 64'd0);
            tick();
            chk("disp_dvalid", 64'(disp_dvalid), 64'd1);
        end
        chk("disp_data", 64'(disp_data), 64'hABCDEF);
        disp_req = 1'b0;
        tick();
        chk("disp_dvalid_fall", 64'(disp_dvalid), 64'd0);

        // Write during blanking, no bypass.
        wr_valid = 1'b1;
        wr_addr  = 19'h00005;
        wr_data  = 24'hFF0000;
        #1;
        chk("blank_ready", 64'(wr_ready), 64'd1);
        chk("blank_nobypass", 64'(ram_we), 64'd0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk_write("blank_wr", 19'h00005, 24'hFF0000);
        tick();
        chk("blank_idle", 64'(ram_we), 64'd0);

        // Starvation: 20 display cycles, 6 push attempts, depth 4.
        disp_req  = 1'b1;
        disp_addr = 19'h00777;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'h00100 + 19'(i);
            wr_data  = 24'h00AA00 + 24'(i);
            #1;
            chk("starve_ready", 64'(wr_ready), (i < 4) ? 64'd1 : 64'd0);
            chk("starve_we", 64'(ram_we), 64'd0);
            chk("starve_addr", 64'(ram_addr), 64'h00777);
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk("starve_hold", 64'(ram_we), 64'd0);
            tick();
        end
        disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_write("drain", 19'h00100 + 19'(i), 24'h00AA00 + 24'(i));
            tick();
        end
        chk("drain_done_we", 64'(ram_we), 64'd0);
        chk("drain_done_ready", 64'(wr_ready), 64'd1);

        // Push and pop in the same cycle at occupancy 3.
        disp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'h00200 + 19'(i);
            wr_data  = 24'h000C00 + 24'(i);
            tick();
        end
        disp_req = 1'b0;
        wr_addr  = 19'h00203;
        wr_data  = 24'h000C03;
        #1;
        chk("pp_ready", 64'(wr_ready), 64'd1);
        chk_write("pp_pop", 19'h00200, 24'h000C00);
        tick();
        disp_req = 1'b1;
        wr_addr  = 19'h00204;
        wr_data  = 24'h000C04;
        #1;
        chk("pp_occ3_ready", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("pp_full", 64'(wr_ready), 64'd0);
        disp_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk_write("pp_drain", 19'h00200 + 19'(i), 24'h000C00 + 24'(i));
            tick();
        end
        chk("pp_empty", 64'(ram_we), 64'd0);

`ifdef VGA_FB_ARB_CLEAR_EN
        // Clear with two pending writes.
        disp_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'h00300 + 19'(i);
            wr_data  = 24'h0000A0 + 24'(i);
            tick();
        end
        wr_valid    = 1'b0;
        clear_start = 1'b1;
        clear_color = 24'h00FF00;
        #1;
        chk("clr_busy_pre", 64'(clear_busy), 64'd0);
        tick();
        clear_start = 1'b0;
        clear_color = 24'h123456;
        #1;
        chk("clr_busy", 64'(clear_busy), 64'd1);
        chk("clr_ready", 64'(wr_ready), 64'd0);
        disp_req = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 19'h003FF;
        #1;
        chk("clr_blocked", 64'(wr_ready), 64'd0);
        chk_write("clr_drain0", 19'h00300, 24'h0000A0);
        tick();
        chk_write("clr_drain1", 19'h00301, 24'h0000A1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("clr_gap_we", 64'(ram_we), 64'd0);
        chk("clr_gap_busy", 64'(clear_busy), 64'd1);
        tick();
        for (int a = 0; a < 16; a++) begin
            if (a == 3) begin
                disp_req = 1'b1;
                #1;
                chk("clr_stall_we", 64'(ram_we), 64'd0);
                tick();
                disp_req = 1'b0;
            end
            if (a == 5) clear_start = 1'b1;
            #1;
            chk_write("clr_sweep", 19'(a), 24'h00FF00);
            chk("clr_sweep_busy", 64'(clear_busy), 64'd1);
            tick();
            clear_start = 1'b0;
        end
        chk("clr_done_busy", 64'(clear_busy), 64'd0);
        chk("clr_done_we", 64'(ram_we), 64'd0);
        chk("clr_done_ready", 64'(wr_ready), 64'd1);
        tick();
        chk("clr_no_restart", 64'(clear_busy), 64'd0);

        // Reset in the middle of a sweep.
        clear_start = 1'b1;
        clear_color = 24'h0000FF;
        tick();
        clear_start = 1'b0;
        #1;
        chk("rst_drain_busy", 64'(clear_busy), 64'd1);
        chk("rst_drain_we", 64'(ram_we), 64'd0);
        tick();
        for (int a = 0; a < 8; a++) begin
            #1;
            chk_write("rst_sweep", 19'(a), 24'h0000FF);
            if (a < 7) tick();
        end
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        chk("rst_after_busy", 64'(clear_busy), 64'd0);
        chk("rst_after_we", 64'(ram_we), 64'd0);
`else
        // Clear engine absent: start pulse has no effect.
        clear_start = 1'b1;
        clear_color = 24'h00FF00;
        tick();
        clear_start = 1'b0;
        #1;
        chk("noclr_busy", 64'(clear_busy), 64'd0);
        chk("noclr_we", 64'(ram_we), 64'd0);
        chk("noclr_ready", 64'(wr_ready), 64'd1);
        tick();
        chk("noclr_we2", 64'(ram_we), 64'd0);

        // Reset with pending writes empties the FIFO.
        disp_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'h00400 + 19'(i);
            wr_data  = 24'h0F0F00 + 24'(i);
            tick();
        end
        wr_valid = 1'b0;
        disp_req = 1'b0;
        #1;
        chk_write("rst_pending", 19'h00400, 24'h0F0F00);
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        chk("rst_after_we", 64'(ram_we), 64'd0);
        chk("rst_after_ready", 64'(wr_ready), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
